d_grf_hazard_ctrl: RTL and testbench
====================================

// Module: d_grf_hazard_ctrl
// PURPOSE
//  Decode-stage hazard controller for the 5-stage MIPS pipeline. Sits beside the GRF.
//  Tracks the pending GRF writes of the instructions in E/M/W with a small shift scoreboard
//  (dest addr + Tnew). Produces the D-stage stall and the forwarding selects for both GRF read ports.
//  Also sequences the multi-cycle MDU busy window that blocks HI/LO accesses.
// PARAMETERS
//  MULT_CYCLES  5   E-stage busy cycles of mult/multu after start
//  DIV_CYCLES   10  E-stage busy cycles of div/divu after start (both params <= 255)
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high reset
//  flush        in   1  exception/eret flush; kills instructions in D, E, M
//  d_rs_addr    in   5  GRF port-1 address of D instr
//  d_rt_addr    in   5  GRF port-2 address of D instr
//  d_rs_tuse    in   2  cycles until rs needed (0..2); 3 = not used
//  d_rt_tuse    in   2  same for rt
//  d_wa         in   5  GRF dest of D instr; 0 = no write
//  d_tnew       in   2  Tnew at E entry: ALU/mf*=1, load=2, jal=0
//  d_md_start   in   1  D instr is mult/multu/div/divu
//  d_md_div     in   1  qualifies d_md_start: 1 = div, 0 = mult
//  d_uses_md    in   1  D instr is md start or mfhi/mflo/mthi/mtlo
//  stall        out  1  freeze PC + F/D reg, insert bubble into E
//  fwd_rs_sel   out  2  0 = GRF (W covered by GRF internal bypass), 1 = from M, 2 = from E
//  fwd_rt_sel   out  2  same encoding for rt
//  md_busy      out  1  MDU op in flight
// BEHAVIOUR
//  Scoreboard: regs E,M,W each {wa[4:0], tnew[1:0]}; bubble = {0,0}. Reset/init: all bubble.
//  Stage shift each posedge (not reset):
//   - E <= stall ? bubble : {d_wa, d_tnew}.
//   - M <= {E.wa, sat0(E.tnew-1)}.
//   - W <= {M.wa, sat0(M.tnew-1)}.
//   - sat0 clamps at 0.
//  flush (priority over shift): E, M, W <= bubble next edge. Killed M instr never writes.
//  Match: stage X matches rs iff X.wa != 0 && X.wa == d_rs_addr && d_rs_tuse != 3 (same for rt).
//  stall_rs = (E match && E.tnew > tuse) || (M match && M.tnew > tuse). W never stalls.
//  stall_rt: same rule on rt.
//  stall_md = d_uses_md && md_busy.
//  stall = (stall_rs | stall_rt | stall_md) & ~flush. Combinational, same cycle.
//  Forward: youngest matching stage wins (E over M). If E matches, sel = 2 only when
//   E.tnew == 0, else 0 (a later-stage mux resolves it); else M match with tnew 0 -> 1; else 0.
//  Forward ignores tuse==3 (sel 0) and addr 0 (sel 0).
//  MDU sequencing: e_md reg (1 bit, + e_div flag) set when d_md_start && !stall && !flush.
//   - Next edge with e_md=1: cnt <= e_div ? DIV_CYCLES : MULT_CYCLES; e_md <= new D value.
//   - Otherwise cnt decrements to 0 and holds. cnt is 8 bits.
//   - md_busy = e_md | (cnt != 0).
//  MDU on flush: e_md <= 0 (killed in E). A running cnt keeps counting (op already issued).
//  Reset: stall=0, fwd_*_sel=0, md_busy=0, cnt=0, e_md=0. A reset mid-MDU op aborts the window.
//  Simultaneous flush+stall conditions: flush wins, stall=0.
//  Outputs fully combinational from scoreboard + D inputs; no extra latency.
// TESTING
//  1. lw $8 in E (tnew 2), D addu rs=$8 tuse 0 -> stall 1,1 then 0 with fwd_rs_sel=0 (lw in W).
//  2. addu $9 in E (tnew 1), D beq rs=$9 tuse 0 -> stall 1 cycle, then fwd_rs_sel=1, stall 0.
//  3. addu $9 in E, D sw rt=$9 tuse 2 -> stall 0, fwd_rt_sel=0; writes to $0 -> never stall/forward.
//  4. jal (wa=31, tnew 0) in E, D jr rs=$31 tuse 0 -> stall 0, fwd_rs_sel=2.
//  5. mult leaves D at t, mflo in D from t+1 -> stall t+1..t+6 (6 cycles), md_busy low at t+7.
//     div with same timing -> 11 stall cycles.
//  6. lw $8 in E, D uses $8, flush=1 -> stall 0 that cycle. Next cycle E/M/W bubble, no stall.
//     reset asserted mid-div -> md_busy 0 next cycle.

Source files
------------

// File: rtl/d_grf_hazard_ctrl.sv
// Decode-stage hazard control: E/M write scoreboard, stall and
// forward selects for both GRF read ports, and the MDU busy window.
module d_grf_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_uses_md,
  output logic       stall,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy
);

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } sb_t;

  // The W entry is served by the GRF internal bypass, so only E and M are held.
  sb_t        r_e, r_m;
  logic       r_e_md, r_e_div;
  logic [7:0] r_cnt;

  logic w_e_rs, w_m_rs, w_e_rt, w_m_rt;
  logic w_stall_rs, w_stall_rt, w_stall_md;
  logic w_stall;

  function automatic logic [1:0] sat0(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  always_comb begin
    w_e_rs = (r_e.wa != 5'd0) && (r_e.wa == d_rs_addr) && (d_rs_tuse != 2'd3);
    w_m_rs = (r_m.wa != 5'd0) && (r_m.wa == d_rs_addr) && (d_rs_tuse != 2'd3);
    w_e_rt = (r_e.wa != 5'd0) && (r_e.wa == d_rt_addr) && (d_rt_tuse != 2'd3);
    w_m_rt = (r_m.wa != 5'd0) && (r_m.wa == d_rt_addr) && (d_rt_tuse != 2'd3);

    w_stall_rs = (w_e_rs && (r_e.tnew > d_rs_tuse)) ||
                 (w_m_rs && (r_m.tnew > d_rs_tuse));
    w_stall_rt = (w_e_rt && (r_e.tnew > d_rt_tuse)) ||
                 (w_m_rt && (r_m.tnew > d_rt_tuse));
    w_stall_md = d_uses_md && md_busy;
    w_stall    = (w_stall_rs | w_stall_rt | w_stall_md) & ~flush;
  end

  // Youngest match wins; an E match not yet ready is resolved later in E.
  always_comb begin
    fwd_rs_sel = 2'd0;
    if (w_e_rs) begin
      if (r_e.tnew == 2'd0) fwd_rs_sel = 2'd2;
    end else if (w_m_rs && (r_m.tnew == 2'd0)) begin
      fwd_rs_sel = 2'd1;
    end
    fwd_rt_sel = 2'd0;
    if (w_e_rt) begin
      if (r_e.tnew == 2'd0) fwd_rt_sel = 2'd2;
    end else if (w_m_rt && (r_m.tnew == 2'd0)) begin
      fwd_rt_sel = 2'd1;
    end
  end

  assign stall   = w_stall;
  assign md_busy = r_e_md | (r_cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e     <= '0;
      r_m     <= '0;
      r_e_md  <= 1'b0;
      r_e_div <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      if (flush) begin
        r_e <= '0;
        r_m <= '0;
      end else begin
        r_e <= w_stall ? sb_t'('0) : sb_t'{d_wa, d_tnew};
        r_m <= sb_t'{r_e.wa, sat0(r_e.tnew)};
      end
      // A flushed MDU op in E never issues; a running count is left alone.
      if (r_e_md && !flush) begin
        r_cnt <= r_e_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      r_e_md  <= d_md_start & ~w_stall & ~flush;
      r_e_div <= d_md_div;
    end
  end

endmodule

// File: tb/tb_d_grf_hazard_ctrl.sv
// Directed bench for d_grf_hazard_ctrl: load-use, branch, store,
// jal/jr, MDU busy windows, flush and reset behaviour.
module tb_d_grf_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [4:0] d_rs_addr, d_rt_addr, d_wa;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_md_start, d_md_div, d_uses_md;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int checks   = 0;
  int failures = 0;
  int n;

  d_grf_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .d_rs_addr  (d_rs_addr),
    .d_rt_addr  (d_rt_addr),
    .d_rs_tuse  (d_rs_tuse),
    .d_rt_tuse  (d_rt_tuse),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_uses_md  (d_uses_md),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    d_rs_addr  = 5'd0;
    d_rt_addr  = 5'd0;
    d_rs_tuse  = 2'd3;
    d_rt_tuse  = 2'd3;
    d_wa       = 5'd0;
    d_tnew     = 2'd0;
    d_md_start = 1'b0;
    d_md_div   = 1'b0;
    d_uses_md  = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic md_window(input logic is_div, input int exp_n, input string tag);
    drain();
    d_md_start = 1'b1;
    d_uses_md  = 1'b1;
    d_md_div   = is_div;
    #1;
    chk({tag, "_start_stall"}, stall, 0);
    tick();
    idle();
    d_uses_md = 1'b1;
    d_wa      = 5'd10;
    d_tnew    = 2'd1;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, n, exp_n);
    chk({tag, "_busy_after"}, md_busy, 0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_rs", fwd_rs_sel, 0);
    chk("rst_fwd_rt", fwd_rt_sel, 0);
    chk("rst_busy", md_busy, 0);

    // lw $8 then addu using $8 at tuse 0
    d_wa = 5'd8; d_tnew = 2'd2;
    #1;
    chk("lw_issue_stall", stall, 0);
    tick();
    idle();
    d_rs_addr = 5'd8; d_rs_tuse = 2'd0;
    d_wa = 5'd10; d_tnew = 2'd1;
    #1;
    chk("lu_stall1", stall, 1);
    tick();
    chk("lu_stall2", stall, 1);
    tick();
    chk("lu_stall3", stall, 0);
    chk("lu_fwd", fwd_rs_sel, 0);

    // addu $9 then beq on $9
    drain();
    d_wa = 5'd9; d_tnew = 2'd1;
    tick();
    idle();
    d_rs_addr = 5'd9; d_rs_tuse = 2'd0;
    #1;
    chk("beq_stall", stall, 1);
    chk("beq_fwd_e", fwd_rs_sel, 0);
    tick();
    chk("beq_stall_m", stall, 0);
    chk("beq_fwd_m", fwd_rs_sel, 1);

    // addu $9 then sw with rt=$9 at tuse 2
    drain();
    d_wa = 5'd9; d_tnew = 2'd1;
    tick();
    idle();
    d_rs_addr = 5'd29; d_rs_tuse = 2'd1;
    d_rt_addr = 5'd9;  d_rt_tuse = 2'd2;
    #1;
    chk("sw_stall", stall, 0);
    chk("sw_fwd_rt_e", fwd_rt_sel, 0);
    tick();
    chk("sw_fwd_rt_m", fwd_rt_sel, 1);

    // writes to $0 are ignored
    drain();
    d_wa = 5'd0; d_tnew = 2'd2;
    tick();
    idle();
    d_rs_addr = 5'd0; d_rs_tuse = 2'd0;
    d_rt_addr = 5'd0; d_rt_tuse = 2'd0;
    #1;
    chk("r0_stall", stall, 0);
    chk("r0_fwd_rs", fwd_rs_sel, 0);
    chk("r0_fwd_rt", fwd_rt_sel, 0);

    // jal then jr $31
    drain();
    d_wa = 5'd31; d_tnew = 2'd0;
    tick();
    idle();
    d_rs_addr = 5'd31; d_rs_tuse = 2'd0;
    #1;
    chk("jr_stall", stall, 0);
    chk("jr_fwd", fwd_rs_sel, 2);
    d_rs_tuse = 2'd3;
    #1;
    chk("jr_tuse3_fwd", fwd_rs_sel, 0);

    md_window(1'b0, 6, "mult");
    md_window(1'b1, 11, "div");

    // flush overrides a load-use stall
    drain();
    d_wa = 5'd8; d_tnew = 2'd2;
    tick();
    idle();
    d_rs_addr = 5'd8; d_rs_tuse = 2'd0;
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("post_flush_stall", stall, 0);
    chk("post_flush_fwd", fwd_rs_sel, 0);

    // reset in the middle of a div window
    drain();
    d_md_start = 1'b1; d_uses_md = 1'b1; d_md_div = 1'b1;
    tick();
    idle();
    tick();
    tick();
    chk("div_busy_mid", md_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_div_busy", md_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
